ft_cmd_ctrl: RTL and testbench
==============================

FT_CMD_CTRL -- requirements
Module: ft_cmd_ctrl

Interface
REQ-001 SHALL have parameter BUILD_ID, default 32'h5052_4F54, value returned for register address 3.
REQ-002 SHALL have port clk_128M  in  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port rst_128M  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port ui_dout  in  16  command word from FT receive FIFO (first-word-fall-through).
REQ-005 SHALL have port ui_dout_empty  in  1  receive FIFO empty.
REQ-006 SHALL have port ui_dout_get  out  1  pop current ui_dout.
REQ-007 SHALL have port ui_din  out  16  response word to FT transmit FIFO.
REQ-008 SHALL have port ui_din_be  out  2  byte enables; constant 2'b11.
REQ-009 SHALL have port ui_din_valid  out  1  ui_din valid.
REQ-010 SHALL have port ui_din_full  in  1  transmit FIFO full; word accepted iff valid && !full.
REQ-011 SHALL have ports total_packets  in  32, mismatch_packets  in  32, okay_led  in  1, link_count_okay  in  1: telemetry status, already in clk_128M domain.
REQ-012 SHALL have port reset_counters  out  1  one-cycle counter-clear pulse.
REQ-013 SHALL have port busy  out  1  high whenever state != IDLE.

Function
REQ-014 Command word SHALL be {opcode[15:8], arg[7:0]}; opcodes: 8'h01 READ_REG, 8'h02 CLR_CNT, 8'h03 ECHO.
REQ-015 States SHALL be IDLE, DECODE, SEND_HDR, SEND_HI, SEND_LO, SEND_ONE.
REQ-016 In IDLE with ui_dout_empty=0, ui_dout_get SHALL pulse for exactly one cycle, ui_dout SHALL be latched, next state DECODE; ui_dout_get SHALL be 0 in every other state.
REQ-017 DECODE SHALL last exactly one cycle; READ_REG with arg 0..3 SHALL snapshot the 32-bit register (0 total_packets, 1 mismatch_packets, 2 {30'b0, link_count_okay, okay_led}, 3 BUILD_ID) into a shadow register, then go to SEND_HDR.
REQ-018 READ_REG response SHALL be three words: {8'hA5, arg}, shadow[31:16], shadow[15:0].
REQ-019 READ_REG with arg >= 4 SHALL produce the single word 16'hEE01.
REQ-020 CLR_CNT SHALL assert reset_counters for exactly the DECODE cycle and produce the single word 16'h5A02.
REQ-021 An unknown opcode SHALL produce the single word 16'hEE00.
REQ-022 In SEND_* states, ui_din_valid SHALL be 1; ui_din SHALL be held stable while ui_din_full=1; state SHALL advance only on an accepted beat.
REQ-023 The last accepted beat SHALL return to IDLE; the next command pop SHALL occur no earlier than the following cycle.
REQ-024 With ui_din_full=0 throughout, latency SHALL be: pop at cycle N, first response word accepted at N+2, READ_REG complete at N+4.
REQ-025 Snapshot inputs changing during SEND_* SHALL NOT alter the words being sent.

Reset
REQ-026 While rst_128M=1: state IDLE; ui_dout_get, ui_din_valid, reset_counters, busy = 0; ui_din = 16'h0000; ui_din_be = 2'b11; shadow = 0.
REQ-027 Reset asserted mid-response SHALL abort the response; no further beats SHALL be sent and no FIFO word SHALL be popped in that cycle.

Configuration
REQ-028 Macro FT_CMD_ECHO_EN defined: ECHO SHALL produce the single word {8'hEC, arg}.
REQ-029 FT_CMD_ECHO_EN undefined: opcode 8'h03 SHALL be treated as unknown (16'hEE00) and no echo logic SHALL be present.

Structure
REQ-030 Package ft_cmd_pkg SHALL hold the opcode constants, response constants (A5, 5A02, EE00, EE01, EC), register addresses and the state enum.
REQ-031 Register select and snapshot SHALL be a sub-module, ft_cmd_reg_mux; the FSM SHALL reside in ft_cmd_ctrl.

Verification
REQ-032 total_packets=32'h1234_5678, cmd 16'h0100, full=0 -> beats 16'hA500, 16'h1234, 16'h5678 at pop+2..+4; busy low after.
REQ-033 cmd 16'h0200 -> reset_counters high exactly one cycle (pop+1); single beat 16'h5A02.
REQ-034 cmd 16'h0103, then cmd 16'h0107 -> BUILD_ID hi/lo after 16'hA503; 16'hEE01 for the second command.
REQ-035 READ_REG 0 with ui_din_full=1 for 5 cycles on the SEND_HI beat and total_packets changed meanwhile -> ui_din held, original snapshot sent, no pop while busy.
REQ-036 cmd 16'h0342 with and without FT_CMD_ECHO_EN -> 16'hEC42 / 16'hEE00; back-to-back queued commands produce responses in order.
REQ-037 Reset during SEND_HDR -> outputs return to reset values next cycle; the next queued command is handled normally.

Source files
------------

// File: rtl/ft_cmd_pkg.sv
// Shared constants and types for the FT command controller.
// Opcodes, response words, register addresses and FSM state encoding.
package ft_cmd_pkg;

  localparam logic [7:0] OpReadReg = 8'h01;
  localparam logic [7:0] OpClrCnt  = 8'h02;
  localparam logic [7:0] OpEcho    = 8'h03;

  localparam logic [7:0]  RspHdr     = 8'hA5;
  localparam logic [7:0]  RspEcho    = 8'hEC;
  localparam logic [15:0] RspClrAck  = 16'h5A02;
  localparam logic [15:0] RspBadOp   = 16'hEE00;
  localparam logic [15:0] RspBadAddr = 16'hEE01;

  localparam logic [1:0] RegTotal    = 2'd0;
  localparam logic [1:0] RegMismatch = 2'd1;
  localparam logic [1:0] RegStatus   = 2'd2;
  localparam logic [1:0] RegBuildId  = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StSendHdr,
    StSendHi,
    StSendLo,
    StSendOne
  } state_e;

  function automatic logic addr_valid(input logic [7:0] arg);
    return arg[7:2] == 6'd0;
  endfunction

endpackage

// File: rtl/ft_cmd_reg_mux.sv
// Register select and snapshot for READ_REG; the shadow copy keeps the
// response stable while live telemetry keeps moving.
module ft_cmd_reg_mux
  import ft_cmd_pkg::*;
#(
  parameter logic [31:0] BUILD_ID = 32'h5052_4F54
) (
  input  logic        clk_128M,
  input  logic        rst_128M,
  input  logic        snap_en,
  input  logic [1:0]  addr,
  input  logic [31:0] total_packets,
  input  logic [31:0] mismatch_packets,
  input  logic        okay_led,
  input  logic        link_count_okay,
  output logic [31:0] shadow
);

  logic [31:0] sel;
  logic [31:0] shadow_d, shadow_q;

  always_comb begin
    sel = 32'h0;
    case (addr)
      RegTotal:    sel = total_packets;
      RegMismatch: sel = mismatch_packets;
      RegStatus:   sel = {30'b0, link_count_okay, okay_led};
      RegBuildId:  sel = BUILD_ID;
      default:     sel = 32'h0;
    endcase
    shadow_d = snap_en ? sel : shadow_q;
  end

  always_ff @(posedge clk_128M) begin
    if (rst_128M) begin
      shadow_q <= 32'h0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign shadow = shadow_q;

endmodule

// File: rtl/ft_cmd_ctrl.sv
// Command decoder/responder between the FT receive and transmit FIFOs.
// Define FT_CMD_ECHO_EN to enable the ECHO opcode; otherwise it is unknown.
module ft_cmd_ctrl
  import ft_cmd_pkg::*;
#(
  parameter logic [31:0] BUILD_ID = 32'h5052_4F54
) (
  input  logic        clk_128M,
  input  logic        rst_128M,
  input  logic [15:0] ui_dout,
  input  logic        ui_dout_empty,
  output logic        ui_dout_get,
  output logic [15:0] ui_din,
  output logic [1:0]  ui_din_be,
  output logic        ui_din_valid,
  input  logic        ui_din_full,
  input  logic [31:0] total_packets,
  input  logic [31:0] mismatch_packets,
  input  logic        okay_led,
  input  logic        link_count_okay,
  output logic        reset_counters,
  output logic        busy
);

  state_e      state_d, state_q;
  logic [15:0] cmd_d, cmd_q;
  logic [15:0] din_d, din_q;
  logic        valid_d, valid_q;
  logic        rst_cnt_d, rst_cnt_q;
  logic        snap_en, pop, accept;
  logic [7:0]  arg;
  logic [31:0] shadow;

  assign arg    = cmd_q[7:0];
  assign accept = valid_q && !ui_din_full;

  ft_cmd_reg_mux #(
    .BUILD_ID(BUILD_ID)
  ) u_reg_mux (
    .clk_128M        (clk_128M),
    .rst_128M        (rst_128M),
    .snap_en         (snap_en),
    .addr            (cmd_q[1:0]),
    .total_packets   (total_packets),
    .mismatch_packets(mismatch_packets),
    .okay_led        (okay_led),
    .link_count_okay (link_count_okay),
    .shadow          (shadow)
  );

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    din_d     = din_q;
    valid_d   = valid_q;
    rst_cnt_d = 1'b0;
    snap_en   = 1'b0;
    pop       = 1'b0;
    case (state_q)
      StIdle: begin
        if (!ui_dout_empty) begin
          pop       = 1'b1;
          cmd_d     = ui_dout;
          // Registered so the pulse lines up exactly with the DECODE cycle.
          rst_cnt_d = (ui_dout[15:8] == OpClrCnt);
          state_d   = StDecode;
        end
      end
      StDecode: begin
        valid_d = 1'b1;
        state_d = StSendOne;
        case (cmd_q[15:8])
          OpReadReg: begin
            if (addr_valid(arg)) begin
              snap_en = 1'b1;
              din_d   = {RspHdr, arg};
              state_d = StSendHdr;
            end else begin
              din_d = RspBadAddr;
            end
          end
          OpClrCnt: din_d = RspClrAck;
`ifdef FT_CMD_ECHO_EN
          OpEcho:   din_d = {RspEcho, arg};
`endif
          default:  din_d = RspBadOp;
        endcase
      end
      StSendHdr: begin
        if (accept) begin
          din_d   = shadow[31:16];
          state_d = StSendHi;
        end
      end
      StSendHi: begin
        if (accept) begin
          din_d   = shadow[15:0];
          state_d = StSendLo;
        end
      end
      StSendLo, StSendOne: begin
        if (accept) begin
          din_d   = 16'h0;
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_128M) begin
    if (rst_128M) begin
      state_q   <= StIdle;
      cmd_q     <= 16'h0;
      din_q     <= 16'h0;
      valid_q   <= 1'b0;
      rst_cnt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      din_q     <= din_d;
      valid_q   <= valid_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  // Gated by reset so an in-flight beat or pop is dropped in the reset cycle itself.
  assign ui_dout_get    = pop && !rst_128M;
  assign ui_din_valid   = valid_q && !rst_128M;
  assign ui_din         = rst_128M ? 16'h0 : din_q;
  assign ui_din_be      = 2'b11;
  assign reset_counters = rst_cnt_q && !rst_128M;
  assign busy           = (state_q != StIdle) && !rst_128M;

endmodule

// File: tb/tb_ft_cmd_ctrl.sv
// Self-checking bench for ft_cmd_ctrl: directed scenarios plus random traffic
// scored against a queue-based response model.
module tb_ft_cmd_ctrl;

  localparam logic [31:0] BuildId = 32'h5052_4F54;

  logic        clk_128M = 1'b0;
  logic        rst_128M = 1'b1;
  logic [15:0] ui_dout = 16'h0;
  logic        ui_dout_empty = 1'b1;
  logic        ui_dout_get;
  logic [15:0] ui_din;
  logic [1:0]  ui_din_be;
  logic        ui_din_valid;
  logic        ui_din_full = 1'b0;
  logic [31:0] total_packets = 32'h0;
  logic [31:0] mismatch_packets = 32'h0;
  logic        okay_led = 1'b0;
  logic        link_count_okay = 1'b0;
  logic        reset_counters;
  logic        busy;

  ft_cmd_ctrl #(
    .BUILD_ID(BuildId)
  ) dut (
    .clk_128M        (clk_128M),
    .rst_128M        (rst_128M),
    .ui_dout         (ui_dout),
    .ui_dout_empty   (ui_dout_empty),
    .ui_dout_get     (ui_dout_get),
    .ui_din          (ui_din),
    .ui_din_be       (ui_din_be),
    .ui_din_valid    (ui_din_valid),
    .ui_din_full     (ui_din_full),
    .total_packets   (total_packets),
    .mismatch_packets(mismatch_packets),
    .okay_led        (okay_led),
    .link_count_okay (link_count_okay),
    .reset_counters  (reset_counters),
    .busy            (busy)
  );

  always #4 clk_128M = ~clk_128M;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Receive FIFO model (first-word-fall-through) and expected response beats.
  logic [15:0] cmdq[$];
  logic [15:0] expq[$];

  task automatic fifo_refresh();
    ui_dout       = (cmdq.size() != 0) ? cmdq[0] : 16'h0000;
    ui_dout_empty = (cmdq.size() == 0);
  endtask

  task automatic push_cmd(input logic [15:0] cmd);
    cmdq.push_back(cmd);
    fifo_refresh();
  endtask

  // Response rules for one command, using telemetry as seen in its decode cycle.
  task automatic model_push(input logic [15:0] cmd);
    logic [7:0]  op;
    logic [7:0]  arg;
    logic [31:0] r;
    op  = cmd[15:8];
    arg = cmd[7:0];
    if (op == 8'h01) begin
      if (arg < 8'd4) begin
        if (arg == 8'd0)      r = total_packets;
        else if (arg == 8'd1) r = mismatch_packets;
        else if (arg == 8'd2) r = {30'b0, link_count_okay, okay_led};
        else                  r = BuildId;
        expq.push_back({8'hA5, arg});
        expq.push_back(r[31:16]);
        expq.push_back(r[15:0]);
      end else begin
        expq.push_back(16'hEE01);
      end
    end else if (op == 8'h02) begin
      expq.push_back(16'h5A02);
`ifdef FT_CMD_ECHO_EN
    end else if (op == 8'h03) begin
      expq.push_back({8'hEC, arg});
`endif
    end else begin
      expq.push_back(16'hEE00);
    end
  endtask

  int          cyc = 0;
  int          pop_cyc = 0;
  int          beat_idx = 0;
  logic        strict = 1'b0;
  logic        rand_mode = 1'b0;
  logic        prev_get = 1'b0;
  logic [15:0] prev_cmd = 16'h0;
  logic        prev_hold = 1'b0;
  logic [15:0] hold_din = 16'h0;
  logic        idle_next = 1'b0;
  logic        pop_pend = 1'b0;

  always @(posedge clk_128M) cyc++;

  always @(posedge clk_128M) begin
    #1;
    if (pop_pend) begin
      void'(cmdq.pop_front());
      pop_pend = 1'b0;
      fifo_refresh();
    end
  end

  // Monitor: sample away from the rising edge.
  always @(negedge clk_128M) begin
    logic [15:0] e;
    if (rst_128M) begin
      check_eq("rst_valid", ui_din_valid, 0);
      check_eq("rst_get", ui_dout_get, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_clr", reset_counters, 0);
      check_eq("rst_din", ui_din, 0);
      check_eq("rst_be", ui_din_be, 2'b11);
      expq.delete();
      prev_get  = 1'b0;
      prev_hold = 1'b0;
      idle_next = 1'b0;
    end else begin
      if (idle_next) check_eq("idle_after_last", busy, 0);
      idle_next = 1'b0;
      if (prev_hold) begin
        check_eq("hold_din", ui_din, hold_din);
        check_eq("hold_valid", ui_din_valid, 1);
      end
      if (prev_get) begin
        check_eq("decode_busy", busy, 1);
        check_eq("decode_clr", reset_counters, prev_cmd[15:8] == 8'h02);
        model_push(prev_cmd);
        beat_idx = 0;
      end else begin
        check_eq("clr_stray", reset_counters, 0);
      end
      if (busy) check_eq("pop_while_busy", ui_dout_get, 0);
      check_eq("be_const", ui_din_be, 2'b11);
      if (ui_din_valid && !ui_din_full) begin
        if (expq.size() == 0) begin
          check_eq("beat_unexpected", ui_din, 32'hFFFF_FFFF);
        end else begin
          e = expq.pop_front();
          check_eq("beat", ui_din, e);
          beat_idx++;
          if (strict) check_eq("latency", cyc - pop_cyc, beat_idx + 1);
          if (expq.size() == 0) idle_next = 1'b1;
        end
      end
      prev_hold = ui_din_valid && ui_din_full;
      hold_din  = ui_din;
      prev_get  = ui_dout_get;
      if (ui_dout_get) begin
        prev_cmd = ui_dout;
        pop_cyc  = cyc;
        pop_pend = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk_128M);
    #1;
    if (rand_mode) begin
      ui_din_full      = ($urandom_range(0, 9) < 3);
      total_packets    = $urandom;
      mismatch_packets = $urandom;
      okay_led         = $urandom_range(0, 1);
      link_count_okay  = $urandom_range(0, 1);
    end
  endtask

  task automatic drain(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (cmdq.size() == 0 && expq.size() == 0 && !busy && !pop_pend) break;
      step();
    end
    if (i >= budget) check_eq("drain_timeout", 0, 1);
  endtask

  task automatic wait_get();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_128M);
      if (ui_dout_get) return;
    end
    check_eq("wait_get_timeout", 0, 1);
  endtask

  initial begin
    logic [7:0] op;
    logic [7:0] arg;
    fifo_refresh();
    repeat (3) step();
    rst_128M = 1'b0;

    // READ_REG 0 with exact latency
    strict = 1'b1;
    total_packets = 32'h1234_5678;
    push_cmd(16'h0100);
    drain(50);
    // CLR_CNT
    push_cmd(16'h0200);
    drain(50);
    // BUILD_ID then an out-of-range address, queued back to back
    push_cmd(16'h0103);
    push_cmd(16'h0107);
    drain(50);
    // ECHO (or unknown when the feature is absent)
    push_cmd(16'h0342);
    push_cmd(16'h0902);
    drain(50);
    mismatch_packets = 32'h0BAD_F00D;
    okay_led = 1'b1;
    push_cmd(16'h0101);
    push_cmd(16'h0102);
    drain(50);

    // Backpressure on SEND_HI while telemetry changes and another command waits
    strict = 1'b0;
    total_packets = 32'hCAFE_0001;
    push_cmd(16'h0100);
    wait_get();
    repeat (3) step();
    ui_din_full   = 1'b1;
    total_packets = 32'hDEAD_BEEF;
    push_cmd(16'h0200);
    repeat (5) step();
    ui_din_full = 1'b0;
    drain(50);

    // Reset during SEND_HDR aborts the response; the queued command survives
    push_cmd(16'h0100);
    push_cmd(16'h0200);
    wait_get();
    repeat (2) step();
    rst_128M = 1'b1;
    step();
    rst_128M = 1'b0;
    drain(50);
    check_eq("after_reset_fifo", cmdq.size(), 0);

    // Random traffic
    rand_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      step();
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 4))
          0, 1:    op = 8'h01;
          2:       op = 8'h02;
          3:       op = 8'h03;
          default: op = $urandom_range(0, 255);
        endcase
        arg = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 6)) : 8'($urandom);
        push_cmd({op, arg});
      end
    end
    drain(2000);
    rand_mode   = 1'b0;
    ui_din_full = 1'b0;
    repeat (2) step();
    check_eq("final_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
